// File: rtl/cache_backing_mem_responder_pkg.sv
// Shared types and constants for the cache backing-memory responder.
package cache_mem_pkg;

  // Responder FSM: normal service, or bulk clear of the store.
  typedef enum logic {
    S_SERVE = 1'b0,
    S_CLEAR = 1'b1
  } mem_state_t;

  // Cycles from request handshake to rsp_data being valid.
  localparam int MEM_RSP_LATENCY = 1;

endpackage

// File: rtl/cache_backing_mem_responder_ram.sv
// Single-port word store: one access per cycle, write has priority,
// read data registered (one cycle latency). Contents are not reset.
module sp_word_ram #(
  parameter int DWIDTH     = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DWIDTH-1:0]     i_wdata,
  output logic [DWIDTH-1:0]     o_rdata
);

  logic [DWIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DWIDTH-1:0] r_rdata;

  // Single access port: write the addressed word, or register a read of it.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cache_backing_mem_responder.sv
// Responder for the direct-mapped cache miss port. Serves cache reads with a
// fixed one-cycle latency from a single-port word store that a host can load
// and that can be bulk-cleared.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. ready may depend combinationally on same-cycle inputs; the
// requester must hold valid and its payload stable until the transfer.
// rsp_data carries no handshake: it is valid the cycle after the read
// transfer and holds until the next accepted read.
module cache_backing_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int                DWIDTH      = 16,
  parameter int                ADDR_WIDTH  = 16,
  parameter logic [DWIDTH-1:0] CLEAR_VALUE = '0,
  parameter int                CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic [DWIDTH-1:0]     rsp_data,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0]     wr_data,
  output logic                  wr_ready,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic [CNT_WIDTH-1:0]  read_count,
  output logic                  dbg_state
);

  localparam int                  DEPTH     = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(DEPTH - 1);

  mem_state_t r_state;
  mem_state_t w_state_next;

  // One bit wider than the store address so the terminal compare cannot wrap.
  logic [ADDR_WIDTH:0]          r_clr_addr;
  logic                         w_clr_start;
  logic                         w_clr_last;
  logic                         w_rd_fire;
  logic                         w_wr_fire;

  logic                         w_ram_we;
  logic                         w_ram_re;
  logic [ADDR_WIDTH-1:0]        w_ram_addr;
  logic [DWIDTH-1:0]            w_ram_wdata;
  logic [DWIDTH-1:0]            w_ram_rdata;

  logic [MEM_RSP_LATENCY-1:0]   r_rd_pending;
  logic                         w_rsp_fresh;
  logic [DWIDTH-1:0]            r_rsp_hold;
  logic                         r_clear_done;
  logic [CNT_WIDTH-1:0]         r_read_count;

  // FSM next state and port readies; readies drop while reset is asserted.
  always_comb begin
    w_state_next = r_state;
    wr_ready     = 1'b0;
    req_ready    = 1'b0;
    w_clr_start  = 1'b0;
    w_clr_last   = 1'b0;
    case (r_state)
      S_SERVE: begin
        wr_ready  = ~reset;
        req_ready = ~reset & ~wr_valid & ~clear_req;
        if (clear_req && !reset) begin
          w_clr_start  = 1'b1;
          w_state_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_clr_last = (r_clr_addr == LAST_ADDR);
        if (w_clr_last) begin
          w_state_next = S_SERVE;
        end
      end
      default: w_state_next = S_SERVE;
    endcase
  end

  assign w_wr_fire = wr_valid & wr_ready;
  assign w_rd_fire = req_valid & req_ready;

  // Store port arbitration: clear sequencer, then host write, then cache read.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_addr  = req_addr;
    w_ram_wdata = wr_data;
    if (r_state == S_CLEAR) begin
      w_ram_we    = ~reset;
      w_ram_addr  = r_clr_addr[ADDR_WIDTH-1:0];
      w_ram_wdata = CLEAR_VALUE;
    end else if (w_wr_fire) begin
      w_ram_we   = 1'b1;
      w_ram_addr = wr_addr;
    end else if (w_rd_fire) begin
      w_ram_re = 1'b1;
    end
  end

  sp_word_ram #(
    .DWIDTH     (DWIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_SERVE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Clear address counter: starts at 0 the cycle after clear_req.
  always_ff @(posedge clk) begin
    if (reset || w_clr_start) begin
      r_clr_addr <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_addr <= r_clr_addr + 1'b1;
    end
  end

  // clear_done pulses in the first serve cycle after the last clear write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clear_done <= 1'b0;
    end else begin
      r_clear_done <= (r_state == S_CLEAR) && w_clr_last;
    end
  end

  // Saturating count of accepted reads, zeroed when a clear starts.
  always_ff @(posedge clk) begin
    if (reset || w_clr_start) begin
      r_read_count <= '0;
    end else if (w_rd_fire && (r_read_count != {CNT_WIDTH{1'b1}})) begin
      r_read_count <= r_read_count + 1'b1;
    end
  end

  // Track which cycle carries fresh RAM data; capture it so it holds afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_pending <= '0;
      r_rsp_hold   <= '0;
    end else begin
      r_rd_pending <= {r_rd_pending, w_rd_fire};
      if (w_rsp_fresh) begin
        r_rsp_hold <= w_ram_rdata;
      end
    end
  end

  assign w_rsp_fresh = r_rd_pending[MEM_RSP_LATENCY-1];
  assign rsp_data    = w_rsp_fresh ? w_ram_rdata : r_rsp_hold;
  assign clear_busy  = (r_state == S_CLEAR);
  assign clear_done  = r_clear_done;
  assign read_count  = r_read_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_cache_backing_mem_responder.sv
// Bench for cache_backing_mem_responder (DWIDTH=16, ADDR_WIDTH=4). A second
// instance with CNT_WIDTH=2 shares all inputs to exercise count saturation.
module tb_cache_backing_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_addr;
  logic        req_ready;
  logic [15:0] rsp_data;
  logic        wr_valid;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        clear_req;
  logic        clear_busy;
  logic        clear_done;
  logic [31:0] read_count;
  logic        dbg_state;

  logic        req_ready2;
  logic [15:0] rsp_data2;
  logic        wr_ready2;
  logic        clear_busy2;
  logic        clear_done2;
  logic [1:0]  read_count2;
  logic        dbg_state2;

  cache_backing_mem_responder #(
    .DWIDTH(16), .ADDR_WIDTH(4), .CLEAR_VALUE(16'h0000), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_data(rsp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
    .read_count(read_count), .dbg_state(dbg_state)
  );

  cache_backing_mem_responder #(
    .DWIDTH(16), .ADDR_WIDTH(4), .CLEAR_VALUE(16'h0000), .CNT_WIDTH(2)
  ) dut_sat (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready2),
    .rsp_data(rsp_data2),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready2),
    .clear_req(clear_req), .clear_busy(clear_busy2), .clear_done(clear_done2),
    .read_count(read_count2), .dbg_state(dbg_state2)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mem_m [16];
  int cnt_m = 0;
  logic hs_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: a read transfer at edge N is compared against the queue
  // head at the falling edge after N.
  always @(posedge clk) hs_d <= req_valid && req_ready;

  always @(negedge clk) begin
    if (hs_d) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual=0x%0h expected=no_response at %0t", rsp_data, $time);
      end else begin
        check("rsp_data", {16'h0, rsp_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) if (clear_done) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver ----------------
  // Drives one cycle of inputs (called at posedge+1), samples readies at the
  // falling edge, returns at the next posedge+1 with inputs idle.
  task automatic cycle_drive(input logic wv, input logic [3:0] wa, input logic [15:0] wd,
                             input logic rv, input logic [3:0] ra, input logic cr,
                             output logic wr_rdy, output logic rd_rdy);
    wr_valid  = wv;
    wr_addr   = wa;
    wr_data   = wd;
    req_valid = rv;
    req_addr  = ra;
    clear_req = cr;
    @(negedge clk);
    wr_rdy = wr_ready;
    rd_rdy = req_ready;
    @(posedge clk);
    #1;
    wr_valid  = 1'b0;
    req_valid = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    logic wr_rdy, rd_rdy;
    cycle_drive(1'b1, a, d, 1'b0, 4'h0, 1'b0, wr_rdy, rd_rdy);
    check("wr_ready", {31'h0, wr_rdy}, 32'h1);
    mem_m[a] = d;
  endtask

  task automatic do_read(input logic [3:0] a);
    logic wr_rdy, rd_rdy;
    exp_q.push_back(mem_m[a]);
    cnt_m++;
    cycle_drive(1'b0, 4'h0, 16'h0, 1'b1, a, 1'b0, wr_rdy, rd_rdy);
    check("req_ready", {31'h0, rd_rdy}, 32'h1);
  endtask

  task automatic check_counts(input string name);
    check({name, "_read_count"}, read_count, cnt_m);
    check({name, "_read_count_sat"}, {30'h0, read_count2}, (cnt_m > 3) ? 32'd3 : cnt_m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        is_wr;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        exp_wr_ready;
    logic        exp_req_ready;
    logic [15:0] exp_rsp;
  } vec_t;

  vec_t vecs[21];

  initial begin
    logic wr_rdy, rd_rdy;
    int base_done;

    for (int i = 0; i < 16; i++)
      vecs[i] = '{1'b1, 4'(i), 16'h1000 + 16'(i), 1'b1, 1'b0, 16'h0};
    vecs[16] = '{1'b0, 4'd3,  16'h0, 1'b1, 1'b1, 16'h1003};
    vecs[17] = '{1'b0, 4'd15, 16'h0, 1'b1, 1'b1, 16'h100F};
    vecs[18] = '{1'b0, 4'd2,  16'h0, 1'b1, 1'b1, 16'h1002};
    vecs[19] = '{1'b0, 4'd5,  16'h0, 1'b1, 1'b1, 16'h1005};
    vecs[20] = '{1'b0, 4'd7,  16'h0, 1'b1, 1'b1, 16'h1007};

    // ---- reset ----
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; clear_req = 1'b0;
    @(negedge clk);
    check("reset_req_ready", {31'h0, req_ready}, 32'h0);
    check("reset_wr_ready", {31'h0, wr_ready}, 32'h0);
    idle(2);
    reset = 1'b0;
    @(negedge clk);
    check("reset_rsp_data", {16'h0, rsp_data}, 32'h0);
    check("reset_clear_busy", {31'h0, clear_busy}, 32'h0);
    check("reset_clear_done", {31'h0, clear_done}, 32'h0);
    check_counts("reset");
    @(posedge clk);
    #1;

    // ---- table: load, single reads, back-to-back reads ----
    for (int i = 0; i < 21; i++) begin
      if (!vecs[i].is_wr) begin
        exp_q.push_back(vecs[i].exp_rsp);
        cnt_m++;
      end
      cycle_drive(vecs[i].is_wr, vecs[i].addr, vecs[i].data,
                  !vecs[i].is_wr, vecs[i].addr, 1'b0, wr_rdy, rd_rdy);
      check("vec_wr_ready", {31'h0, wr_rdy}, {31'h0, vecs[i].exp_wr_ready});
      check("vec_req_ready", {31'h0, rd_rdy}, {31'h0, vecs[i].exp_req_ready});
      if (vecs[i].is_wr) mem_m[vecs[i].addr] = vecs[i].data;
    end
    @(negedge clk);
    check_counts("b2b");
    @(posedge clk);
    #1;

    // ---- write and read in the same cycle: write wins ----
    cycle_drive(1'b1, 4'd5, 16'hBEEF, 1'b1, 4'd5, 1'b0, wr_rdy, rd_rdy);
    check("collide_wr_ready", {31'h0, wr_rdy}, 32'h1);
    check("collide_req_ready", {31'h0, rd_rdy}, 32'h0);
    mem_m[5] = 16'hBEEF;
    do_read(4'd5);

    // ---- rsp_data holds across idle cycles ----
    do_read(4'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rsp_hold", {16'h0, rsp_data}, {16'h0, mem_m[4]});
      @(posedge clk);
      #1;
    end
    do_read(4'd6);
    idle(1);
    @(negedge clk);
    check_counts("pre_clear");
    @(posedge clk);
    #1;

    // ---- full clear ----
    base_done = done_cnt;
    cycle_drive(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b1, wr_rdy, rd_rdy);
    check("clear_req_ready", {31'h0, rd_rdy}, 32'h0);
    cnt_m = 0;
    req_valid = 1'b1;
    req_addr  = 4'd3;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("clear_busy", {31'h0, clear_busy}, 32'h1);
      check("clear_req_ready_busy", {31'h0, req_ready}, 32'h0);
      check("clear_wr_ready_busy", {31'h0, wr_ready}, 32'h0);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("clear_busy_end", {31'h0, clear_busy}, 32'h0);
    check("clear_done_pulse", {31'h0, clear_done}, 32'h1);
    check_counts("clear");
    @(posedge clk);
    #1;
    @(negedge clk);
    check("clear_done_single", {31'h0, clear_done}, 32'h0);
    check("clear_done_count", done_cnt - base_done, 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) mem_m[i] = 16'h0000;
    do_read(4'd9);
    do_read(4'(16'($urandom_range(0, 15))));
    idle(1);
    @(negedge clk);
    check_counts("post_clear");
    @(posedge clk);
    #1;

    // ---- reset during a clear ----
    do_write(4'd1, 16'h2001);
    do_write(4'd12, 16'h200C);
    base_done = done_cnt;
    cycle_drive(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b1, wr_rdy, rd_rdy);
    idle(5);
    reset = 1'b1;
    req_valid = 1'b1;
    req_addr = 4'd12;
    @(negedge clk);
    check("midreset_req_ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    idle(1);
    reset = 1'b0;
    cnt_m = 0;
    for (int i = 0; i < 5; i++) mem_m[i] = 16'h0000;
    @(negedge clk);
    check("midreset_clear_busy", {31'h0, clear_busy}, 32'h0);
    check("midreset_rsp_data", {16'h0, rsp_data}, 32'h0);
    check_counts("midreset");
    @(posedge clk);
    #1;
    do_read(4'd1);
    do_read(4'd12);
    idle(20);
    check("midreset_no_done", done_cnt - base_done, 32'd0);

    // ---- a few random write/read pairs ----
    for (int i = 0; i < 6; i++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 15));
      do_write(a, 16'($urandom_range(0, 65535)));
      do_read(a);
    end
    idle(2);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check_counts("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
